// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder with LATENCY wait states and byte/half/word access
// Optional feature: define DMEM_STATS_EN to add load/store/error commit counters.
module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
`ifdef DMEM_STATS_EN
  ,
  output logic [31:0] stat_loads,
  output logic [31:0] stat_stores,
  output logic [31:0] stat_errs
`endif
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t      state;
  logic [3:0]  cnt;
  logic        we_q, uns_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] mem [DEPTH];
  logic        we, uns, accept, commit, err;
  logic [1:0]  size;
  logic [31:0] addr, wdata, old, sh, ld, wd, merged;
  logic [3:0]  be;
  logic [AW-1:0] idx;
  // With LATENCY=0 the commit happens on the accept edge, so the live request is used in IDLE.
  assign we     = state == IDLE ? req_we       : we_q;
  assign uns    = state == IDLE ? req_unsigned : uns_q;
  assign size   = state == IDLE ? req_size     : size_q;
  assign addr   = state == IDLE ? req_addr     : addr_q;
  assign wdata  = state == IDLE ? req_wdata    : wdata_q;
  assign accept = req_valid & req_ready;
  assign commit = state == IDLE ? accept && LATENCY == 0 : state == WAIT && cnt == 4'd0;
  assign err    = size == 2'b11 || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00)
                  || addr >= 32'(DEPTH * 4);
  assign idx    = addr[AW+1:2];
  assign old    = mem[idx];
  assign sh     = old >> {addr[1:0], 3'b000};
  assign ld     = size == 2'b00 ? {{24{~uns & sh[7]}}, sh[7:0]}
                : size == 2'b01 ? {{16{~uns & sh[15]}}, sh[15:0]} : sh;
  assign be     = size == 2'b00 ? 4'b0001 << addr[1:0]
                : size == 2'b01 ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wd     = size == 2'b00 ? {4{wdata[7:0]}} : size == 2'b01 ? {2{wdata[15:0]}} : wdata;
  // Byte-lane merge of store data into the existing word
  always_comb begin
    merged = old;
    for (int i = 0; i < 4; i++) merged[i*8 +: 8] = be[i] ? wd[i*8 +: 8] : old[i*8 +: 8];
  end
  // Memory array: written only at a non-erroring store commit outside reset
  always_ff @(posedge clk) begin
    if (reset_n && commit && we && !err) mem[idx] <= merged;
  end
  // Request/response FSM with registered handshake outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        we_q      <= req_we;
        uns_q     <= req_unsigned;
        size_q    <= req_size;
        addr_q    <= req_addr;
        wdata_q   <= req_wdata;
        req_ready <= 1'b0;
      end
      if (commit) begin
        state      <= RESP;
        resp_valid <= 1'b1;
        resp_rdata <= err || we ? 32'd0 : ld;
        resp_err   <= err;
      end else if (accept) begin
        state <= WAIT;
        cnt   <= 4'(LATENCY > 0 ? LATENCY - 1 : 0);
      end else if (state == IDLE) begin
        req_ready <= 1'b1;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end else if (resp_ready) begin
        state      <= IDLE;
        resp_valid <= 1'b0;
        resp_rdata <= 32'd0;
        resp_err   <= 1'b0;
        req_ready  <= 1'b1;
      end
    end
  end
`ifdef DMEM_STATS_EN
  // Commit counters, one per outcome, wrapping naturally
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stat_loads  <= 32'd0;
      stat_stores <= 32'd0;
      stat_errs   <= 32'd0;
    end else if (commit) begin
      stat_errs   <= stat_errs + {31'd0, err};
      stat_stores <= stat_stores + {31'd0, ~err & we};
      stat_loads  <= stat_loads + {31'd0, ~err & ~we};
    end
  end
`endif
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder (LATENCY=2, DEPTH=256)
module tb_dmem_responder;
  localparam int DEPTH = 256;
  localparam int LAT   = 2;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0, resp_ready = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  int          checks = 0, errors = 0;
  int          n_loads = 0, n_stores = 0, n_errs = 0;
  logic [32:0] sbq [$];
`ifdef DMEM_STATS_EN
  logic [31:0] stat_loads, stat_stores, stat_errs;
`endif

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err)
`ifdef DMEM_STATS_EN
    , .stat_loads(stat_loads), .stat_stores(stat_stores), .stat_errs(stat_errs)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_seen", {31'd0, req_ready}, 32'd1);
  endtask

  // One transaction: drive, push expectation, await response, hold for 'hold' cycles, retire
  task automatic xact(input string tag, input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err, input int hold);
    int n = 0;
    logic [32:0] e;
    wait_ready();
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    sbq.push_back({exp_err, exp_rdata});
    if (exp_err) n_errs++; else if (we) n_stores++; else n_loads++;
    @(posedge clk);
    #1 req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h0BAD_0BAD;
    do begin
      @(negedge clk);
      n++;
    end while (!resp_valid && n < 40);
    check({tag, "_latency"}, n, LAT + 1);
    e = sbq.pop_front();
    check({tag, "_rdata"}, resp_rdata, e[31:0]);
    check({tag, "_err"}, {31'd0, resp_err}, {31'd0, e[32]});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, {31'd0, resp_valid}, 32'd1);
      check({tag, "_hold_rdata"}, resp_rdata, e[31:0]);
      check({tag, "_hold_ready"}, {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    check({tag, "_retire_valid"}, {31'd0, resp_valid}, 32'd0);
    check({tag, "_retire_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, {31'd0, req_ready}, 32'd0);
    check({tag, "_valid"}, {31'd0, resp_valid}, 32'd0);
    check({tag, "_rdata"}, resp_rdata, 32'd0);
    check({tag, "_err"}, {31'd0, resp_err}, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    @(negedge clk);
    check("ready_after_release", {31'd0, req_ready}, 32'd1);
    // Word store/load
    xact("sw10", 1, 2'b10, 0, 32'h10, 32'h1234_5678, 32'h0, 0, 0);
    xact("lw10", 0, 2'b10, 0, 32'h10, 32'h0, 32'h1234_5678, 0, 0);
    // Byte store and extensions
    xact("sb11", 1, 2'b00, 0, 32'h11, 32'hFFFF_FFAB, 32'h0, 0, 0);
    xact("lb11", 0, 2'b00, 0, 32'h11, 32'h0, 32'hFFFF_FFAB, 0, 0);
    xact("lbu11", 0, 2'b00, 1, 32'h11, 32'h0, 32'h0000_00AB, 0, 0);
    xact("lw10b", 0, 2'b10, 0, 32'h10, 32'h0, 32'h1234_AB78, 0, 0);
    // Half store/load, misaligned accesses
    xact("sh12", 1, 2'b01, 0, 32'h12, 32'h7777_8000, 32'h0, 0, 0);
    xact("lh12", 0, 2'b01, 0, 32'h12, 32'h0, 32'hFFFF_8000, 0, 0);
    xact("lhu12", 0, 2'b01, 1, 32'h12, 32'h0, 32'h0000_8000, 0, 0);
    xact("lh13", 0, 2'b01, 0, 32'h13, 32'h0, 32'h0, 1, 0);
    xact("sw14", 1, 2'b10, 0, 32'h14, 32'h1122_3344, 32'h0, 0, 0);
    xact("sw16", 1, 2'b10, 0, 32'h16, 32'hFFFF_FFFF, 32'h0, 1, 0);
    xact("lw14", 0, 2'b10, 0, 32'h14, 32'h0, 32'h1122_3344, 0, 0);
    xact("sb17", 1, 2'b00, 0, 32'h17, 32'h0000_005A, 32'h0, 0, 0);
    xact("sh14", 1, 2'b01, 0, 32'h14, 32'h0000_BEEF, 32'h0, 0, 0);
    xact("lw14b", 0, 2'b10, 0, 32'h14, 32'h0, 32'h5A22_BEEF, 0, 0);
    xact("lb17", 0, 2'b00, 0, 32'h17, 32'h0, 32'h0000_005A, 0, 0);
    xact("lhu14", 0, 2'b01, 1, 32'h14, 32'h0, 32'h0000_BEEF, 0, 0);
    // Backpressure: response held five cycles
    xact("lw_bp", 0, 2'b10, 0, 32'h10, 32'h0, 32'h8000_AB78, 0, 5);
`ifdef DMEM_STATS_EN
    check("stat_loads", stat_loads, n_loads);
    check("stat_stores", stat_stores, n_stores);
    check("stat_errs", stat_errs, n_errs);
`endif
    // Reset during WAIT of a store abandons it
    xact("sw20", 1, 2'b10, 0, 32'h20, 32'hCAFE_F00D, 32'h0, 0, 0);
    wait_ready();
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h20; req_wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midreset");
    n_loads = 0; n_stores = 0; n_errs = 0;
    reset_n = 1'b1;
    xact("lw20", 0, 2'b10, 0, 32'h20, 32'h0, 32'hCAFE_F00D, 0, 0);
    // Range and size boundaries
    xact("lw_oor", 0, 2'b10, 0, DEPTH * 4, 32'h0, 32'h0, 1, 0);
    xact("sb_top", 1, 2'b00, 0, DEPTH * 4 - 1, 32'h0000_0080, 32'h0, 0, 0);
    xact("lb_top", 0, 2'b00, 0, DEPTH * 4 - 1, 32'h0, 32'hFFFF_FF80, 0, 0);
    xact("size11", 0, 2'b11, 0, 32'h10, 32'h0, 32'h0, 1, 0);
    xact("sw_oor", 1, 2'b10, 0, 32'h0000_1000, 32'h1, 32'h0, 1, 0);
`ifdef DMEM_STATS_EN
    check("stat_loads2", stat_loads, n_loads);
    check("stat_stores2", stat_stores, n_stores);
    check("stat_errs2", stat_errs, n_errs);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
